// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: types and constants shared by the fetch stage and the
// downstream IF/ID and ID stages.
package pc_fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned INST_W_DEFAULT = 32;

  // First fetch address after reset (MIPS-style boot vector).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Instruction presented while nothing has been fetched yet.
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
  typedef logic [INST_W_DEFAULT-1:0] inst_t;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Next-pc source selection.
  typedef enum logic [1:0] {
    PC_SEL_HOLD  = 2'd0,
    PC_SEL_INC   = 2'd1,
    PC_SEL_REDIR = 2'd2,
    PC_SEL_RESET = 2'd3
  } pc_sel_t;

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch_pc_next_sel.sv
// pc_next_sel: combinational next-pc mux for the fetch stage.
// Redirect targets are forced word aligned; the increment wraps naturally
// at 2^ADDR_W.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  pc_sel_t           sel_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  // Low address bits of a redirect target carry no meaning for a word fetch.
  logic [1:0] redirect_lsb_unused;
  assign redirect_lsb_unused = redirect_pc_i[1:0];

  // Select the program counter value for the next cycle.
  always_comb begin
    pc_next_o = pc_i;
    case (sel_i)
      PC_SEL_HOLD:  pc_next_o = pc_i;
      PC_SEL_INC:   pc_next_o = pc_i + ADDR_W'(4);
      PC_SEL_REDIR: pc_next_o = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      PC_SEL_RESET: pc_next_o = RESET_PC;
      default:      pc_next_o = pc_i;
    endcase
  end

endmodule : pc_next_sel

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage feeding the IF/ID register.
// Owns the pc, issues one imem request at a time (req/gnt/rvalid) and
// presents {out_inst, out_pc, out_valid}. Redirects flush any in-flight
// response; stall freezes the output and blocks new requests.
// Optional build macro PC_FETCH_STAT_EN adds stat_fetched and
// stat_stall_cyc counters.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned       INST_W   = INST_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
`ifdef PC_FETCH_STAT_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stall_cyc
`endif
);

  fetch_state_t      state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic              kill_q,      kill_d;
  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0] out_pc_q,    out_pc_d;
  logic              imem_req_q,  imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;

  pc_sel_t pc_sel;
  logic    rsp_capture;

  pc_next_sel #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .sel_i         (pc_sel),
    .pc_i          (pc_q),
    .redirect_pc_i (redirect_pc),
    .pc_next_o     (pc_d)
  );

  // Next-state decode: sequencing, pc source, kill flag and output capture.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    pc_sel      = PC_SEL_HOLD;
    rsp_capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_sel  = PC_SEL_REDIR;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (redirect_valid) begin
          pc_sel = PC_SEL_REDIR;
          if (imem_gnt) begin
            // The just-granted fetch is stale; swallow its response.
            kill_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end else if (imem_gnt) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          // The single outstanding response has landed; nothing else is owed.
          kill_d = 1'b0;
          if (redirect_valid) begin
            pc_sel  = PC_SEL_REDIR;
            state_d = REQ;
          end else if (kill_q) begin
            state_d = REQ;
          end else begin
            rsp_capture = 1'b1;
            pc_sel      = PC_SEL_INC;
            state_d     = stall ? HOLD : REQ;
          end
        end else if (redirect_valid) begin
          kill_d  = 1'b1;
          pc_sel  = PC_SEL_REDIR;
          state_d = WAIT;
        end else begin
          state_d = WAIT;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_sel  = PC_SEL_REDIR;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase

    // A live instruction survives only while the pipeline is stalled;
    // a redirect always flushes it.
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = rsp_capture | (out_valid_q & stall);
    end

    if (rsp_capture) begin
      out_inst_d = imem_rdata;
      out_pc_d   = pc_q;
    end else begin
      out_inst_d = out_inst_q;
      out_pc_d   = out_pc_q;
    end

    // Request lines are registered from the next state so they are glitch-free.
    imem_req_d = (state_d == REQ);
    if (state_d == REQ) begin
      imem_addr_d = pc_d;
    end else begin
      imem_addr_d = imem_addr_q;
    end
  end

  // Fetch state, pc and registered output/request lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= INST_W'(INST_NOP);
      out_pc_q    <= {ADDR_W{1'b0}};
      imem_req_q  <= 1'b0;
      imem_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;

`ifdef PC_FETCH_STAT_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_stall_cyc_q;

  // Count captured responses and stalled cycles; both wrap at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched_q   <= 32'd0;
      stat_stall_cyc_q <= 32'd0;
    end else begin
      stat_fetched_q   <= stat_fetched_q + {31'd0, rsp_capture};
      stat_stall_cyc_q <= stat_stall_cyc_q + {31'd0, stall};
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_stall_cyc = stat_stall_cyc_q;
`endif

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios plus randomized traffic for pc_fetch,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef PC_FETCH_STAT_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall_cyc;
`endif

  int checks;
  int failures;
  bit chk_en;

  // Model: what the fetch stage is doing, in transaction terms.
  bit          m_started;     // idle cycle after reset done
  bit          m_requesting;  // a request is being presented
  bit          m_inflight;    // a granted request awaits its response
  bit          m_drop;        // the in-flight response is stale
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_out_inst;
  logic [31:0] m_out_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;

  // Memory environment.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] pend_addr;
  int          gnt_mode;   // 0 random, 1 always, 2 never
  int          lat_mode;   // 0 random 1..3, else fixed latency
  bit          ovr_en;
  logic [31:0] ovr_data;

  pc_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef PC_FETCH_STAT_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_stall_cyc (stat_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started    = 1'b0;
    m_requesting = 1'b0;
    m_inflight   = 1'b0;
    m_drop       = 1'b0;
    m_valid      = 1'b0;
    m_pc         = 32'hBFC0_0000;
    m_out_inst   = 32'h0;
    m_out_pc     = 32'h0;
    m_fetched    = 32'h0;
    m_stall      = 32'h0;
  endtask

  task automatic mem_reset();
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_addr    = 32'h0;
    pend_addr   = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // One clock edge of the fetch stage, as seen from the pipeline.
  task automatic model_step();
    logic [31:0] tgt;
    bit          cap;
    tgt = {redirect_pc[31:2], 2'b00};
    cap = 1'b0;
    if (!m_started) begin
      if (redirect_valid || !stall) begin
        m_started    = 1'b1;
        m_requesting = 1'b1;
        if (redirect_valid) m_pc = tgt;
      end
    end else if (m_requesting) begin
      if (imem_gnt) begin
        m_requesting = 1'b0;
        m_inflight   = 1'b1;
        m_drop       = redirect_valid;
      end
      if (redirect_valid) m_pc = tgt;
    end else if (m_inflight) begin
      if (imem_rvalid) begin
        m_inflight = 1'b0;
        if (redirect_valid) begin
          m_pc = tgt; m_requesting = 1'b1; m_drop = 1'b0;
        end else if (m_drop) begin
          m_drop = 1'b0; m_requesting = 1'b1;
        end else begin
          cap          = 1'b1;
          m_out_inst   = memfn(m_pc);
          m_out_pc     = m_pc;
          m_pc         = m_pc + 32'd4;
          m_requesting = !stall;
          m_fetched    = m_fetched + 32'd1;
        end
      end else if (redirect_valid) begin
        m_pc = tgt; m_drop = 1'b1;
      end
    end else begin
      // holding a fetched instruction under stall
      if (redirect_valid || !stall) begin
        m_requesting = 1'b1;
        if (redirect_valid) m_pc = tgt;
      end
    end
    m_valid = !redirect_valid && (cap || (m_valid && stall));
    if (stall) m_stall = m_stall + 32'd1;
  endtask

  task automatic mem_step();
    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (imem_gnt) begin
      mem_busy = 1'b1;
      mem_addr = pend_addr;
      mem_cnt  = ((lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode) - 1;
    end
  endtask

  task automatic drive_mem();
    bit g;
    g = 1'b0;
    if (imem_req) begin
      case (gnt_mode)
        1:       g = 1'b1;
        2:       g = 1'b0;
        default: g = ($urandom_range(0, 99) < 60);
      endcase
    end
    imem_gnt = g;
    if (g) pend_addr = imem_addr;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    if (imem_rvalid) imem_rdata = ovr_en ? ovr_data : memfn(mem_addr);
    else             imem_rdata = $urandom();
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_reset();
      mem_reset();
    end else begin
      model_step();
      mem_step();
    end
    @(negedge clk);
    #1;
    drive_mem();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, output bit dead_seen);
    bit found;
    found     = 1'b0;
    dead_seen = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (out_inst === 32'hDEAD_BEEF) dead_seen = 1'b1;
      if (out_valid === 1'b1) found = 1'b1;
    end
    cmp({name, "_seen"}, {31'd0, found}, 32'd1);
    if (found) cmp({name, "_pc"}, out_pc, exp_pc);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req", {31'd0, imem_req}, {31'd0, (m_started && m_requesting)});
      if (m_started && m_requesting) cmp("imem_addr", imem_addr, m_pc);
      cmp("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        cmp("out_inst", out_inst, m_out_inst);
        cmp("out_pc", out_pc, m_out_pc);
      end
      if (!rst) begin
        cmp("rst_imem_addr", imem_addr, 32'h0);
        cmp("rst_out_inst", out_inst, 32'h0);
        cmp("rst_out_pc", out_pc, 32'h0);
      end
`ifdef PC_FETCH_STAT_EN
      cmp("stat_fetched", stat_fetched, m_fetched);
      cmp("stat_stall_cyc", stat_stall_cyc, m_stall);
`endif
    end
  end

  initial begin
    logic [31:0] pcs [3];
    int          at  [3];
    int          idx;
    bit          dead;
    bit          got;

    clk = 1'b0; rst = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
    gnt_mode = 2; lat_mode = 1; ovr_en = 1'b0; ovr_data = 32'h0;
    checks = 0; failures = 0; chk_en = 1'b0;
    model_reset();
    mem_reset();
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();

    // Reset values.
    cmp("reset_req", {31'd0, imem_req}, 32'd0);
    cmp("reset_addr", imem_addr, 32'h0);
    cmp("reset_valid", {31'd0, out_valid}, 32'd0);
    cmp("reset_inst", out_inst, 32'h0);
    cmp("reset_pc", out_pc, 32'h0);

    // First request after the idle cycle; gnt held low three cycles.
    rst = 1'b1;
    step();
    cmp("first_req", {31'd0, imem_req}, 32'd1);
    cmp("first_addr", imem_addr, 32'hBFC0_0000);
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("nogrant_req", {31'd0, imem_req}, 32'd1);
      cmp("nogrant_addr", imem_addr, 32'hBFC0_0000);
    end

    // Sequential fetch with single-cycle memory.
    gnt_mode = 1;
    drive_mem();
    idx = 0;
    for (int k = 0; k < 3; k++) begin pcs[k] = 32'h0; at[k] = 0; end
    for (int s = 0; s < 8; s++) begin
      step();
      if (out_valid === 1'b1 && idx < 3) begin
        pcs[idx] = out_pc; at[idx] = s; idx++;
      end
    end
    cmp("seq_count", 32'(idx), 32'd3);
    cmp("seq_pc0", pcs[0], 32'hBFC0_0000);
    cmp("seq_pc1", pcs[1], 32'hBFC0_0004);
    cmp("seq_pc2", pcs[2], 32'hBFC0_0008);
    cmp("seq_gap01", 32'(at[1] - at[0]), 32'd2);
    cmp("seq_gap12", 32'(at[2] - at[1]), 32'd2);

    // Redirect while a response is outstanding; the stale data is dropped.
    lat_mode = 2;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (imem_req === 1'b1 && imem_gnt === 1'b1) got = 1'b1;
      else step();
    end
    cmp("redir_setup", {31'd0, got}, 32'd1);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    step();
    redirect_valid = 1'b0;
    step();
    ovr_en = 1'b0;
    cmp("redir_req", {31'd0, imem_req}, 32'd1);
    cmp("redir_addr", imem_addr, 32'h8000_0100);
    wait_valid("redir_fetch", 32'h8000_0100, dead);
    cmp("redir_no_stale", {31'd0, dead}, 32'd0);

    // Stall across the response: output held, no request, then pc+4.
    step();
    stall = 1'b1;
    step();
    step();
    cmp("stall_valid", {31'd0, out_valid}, 32'd1);
    cmp("stall_pc", out_pc, 32'h8000_0104);
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      cmp("stall_hold_inst", out_inst, memfn(32'h8000_0104));
      cmp("stall_hold_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    cmp("unstall_req", {31'd0, imem_req}, 32'd1);
    cmp("unstall_addr", imem_addr, 32'h8000_0108);
    cmp("unstall_valid", {31'd0, out_valid}, 32'd0);

    // Redirect and stall together while holding.
    step();
    stall = 1'b1;
    step();
    step();
    cmp("hold2_valid", {31'd0, out_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    step();
    cmp("hold_redir_valid", {31'd0, out_valid}, 32'd0);
    cmp("hold_redir_req", {31'd0, imem_req}, 32'd1);
    cmp("hold_redir_addr", imem_addr, 32'h0000_1000);
    redirect_valid = 1'b0; stall = 1'b0;

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_valid("wrap_fetch", 32'hFFFF_FFFC, dead);
    cmp("wrap_req", {31'd0, imem_req}, 32'd1);
    cmp("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset while a response is outstanding, then stall through the idle cycle.
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (m_inflight) got = 1'b1;
      else step();
    end
    cmp("rst_mid_setup", {31'd0, got}, 32'd1);
    #3;
    rst = 1'b0;
    model_reset();
    mem_reset();
    step();
    step();
    stall = 1'b1;
    rst = 1'b1;
    step();
    cmp("idle_stall_req", {31'd0, imem_req}, 32'd0);
    step();
    cmp("idle_stall_req2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    cmp("after_rst_addr", imem_addr, 32'hBFC0_0000);

    // Randomized traffic.
    gnt_mode = 0;
    lat_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 99) < 20);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_pc    = $urandom();
      if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      step();
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc_fetch

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Presents {inst, pc_addr, valid} to IF/ID.
- Honours jump redirects (flush) and full-pipeline stalls (hold).

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- redirect_valid  in  1  jump/branch taken; flush and refetch from redirect_pc.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0).
- stall  in  1  full-pipeline stall; hold the output, issue no new request.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; at least 1 cycle after gnt.
- imem_rdata  in  INST_W  response instruction.
- out_valid  out  1  out_inst/out_pc hold a live instruction.
- out_inst  out  INST_W  fetched instruction to IF/ID.
- out_pc  out  ADDR_W  address of out_inst.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE, kill=0.
  - out_valid=0, out_inst=0, out_pc=0, imem_req=0, imem_addr=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT. imem_addr is stable until gnt.
  - WAIT: imem_req=0. On imem_rvalid with kill=0:
    - capture out_inst=imem_rdata and out_pc=pc; out_valid=1 next cycle; pc+=4 (wraps mod 2^ADDR_W).
    - Go to HOLD if stall=1, else REQ.
  - WAIT, imem_rvalid with kill=1: drop the data, clear kill, go to REQ.
  - HOLD: outputs frozen, out_valid=1, no request. On stall=0, go to REQ.
- out_valid is a 1-cycle pulse per instruction when not stalled. It clears the cycle after the consuming edge unless a new response lands that cycle.
- Single-cycle memory gives throughput of 1 instruction per 2 cycles; latency from gnt to out_valid is rvalid latency + 1.
- Redirect, by state:
  - REQ without gnt: pc=redirect_pc next cycle, stay in REQ; address changes next cycle.
  - REQ with gnt same cycle, or WAIT: kill=1, pc=redirect_pc, go/stay WAIT; the in-flight response is discarded.
  - IDLE or HOLD: pc=redirect_pc, go to REQ.
  - All states: out_valid=0 next cycle.
- Simultaneous events:
  - redirect_valid with stall: redirect wins; flush, out_valid=0.
  - redirect_valid with rvalid in WAIT: response discarded, no out_valid.
  - stall during REQ: request is still presented until gnt; its response is captured and the FSM enters HOLD.
  - stall during IDLE: remain in IDLE.
- Reset mid-WAIT: the outstanding response is lost. The memory is reset by the same rst, so no stray rvalid is expected.

Optional Feature:
- PC_FETCH_STAT_EN defined: adds outputs stat_fetched[31:0] and stat_stall_cyc[31:0].
  - stat_fetched increments on each non-killed rvalid.
  - stat_stall_cyc increments on each cycle with stall=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared cpu package holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}.
  - RESET_PC_DEFAULT constant.
  - INST_NOP = 32'h0 constant.
  - addr_t and inst_t typedefs, shared with IF/ID and ID.
- One natural sub-module, pc_next_sel: combinational next-pc mux (reset / redirect / pc+4 / hold).

Test Plan:
- Reset release, memory answers rvalid 1 cycle after gnt:
  - first imem_addr=BFC00000; out_pc sequence BFC00000, BFC00004, BFC00008.
  - out_valid pulses every 2nd cycle.
- Hold gnt low for 3 cycles in REQ: imem_req and imem_addr=BFC00000 stay stable; a single response yields a single out_valid.
- redirect_valid=1, redirect_pc=80000102 during WAIT; then rvalid with rdata=DEADBEEF:
  - DEADBEEF never appears on the output.
  - next imem_addr=80000100; out_pc=80000100 after its response.
- stall=1 asserted before rvalid for 5 cycles:
  - out_valid=1 with out_inst held over the whole stall; no imem_req.
  - after stall=0, next request is at pc+4.
- redirect_valid and stall both 1 in HOLD: out_valid=0 next cycle; request to the redirect target is issued.
- pc=FFFFFFFC fetched: next imem_addr=00000000 (wrap).
- With PC_FETCH_STAT_EN defined: stat_fetched increments per captured response; stat_stall_cyc counts stall cycles.
